// File: rtl/typer_pkg.sv
// Shared definitions for the typing checker: FSM encoding and PS/2 set-2 prefix/shift bytes.
package typer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_LOAD        = 3'd1;
  localparam state_t ST_CHECK_EMPTY = 3'd2;
  localparam state_t ST_WAIT_KEY    = 3'd3;
  localparam state_t ST_COMPARE     = 3'd4;
  localparam state_t ST_ADVANCE     = 3'd5;
  localparam state_t ST_LEVEL_DONE  = 3'd6;
  localparam state_t ST_GAME_OVER   = 3'd7;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  function automatic logic is_shift(input logic [7:0] b);
    return (b == PS2_LSHIFT) || (b == PS2_RSHIFT);
  endfunction

endpackage

// File: rtl/typing_checker_if.sv
// Scan-byte input and parser handshake between the typing checker and its neighbours.
interface typing_checker_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic [7:0] comparison_data;
  logic [7:0] num_char;
  logic       get_next_character;
  logic       enable_next_level;

  modport master (
    output scan_valid, scan_code, comparison_data, num_char,
    input  get_next_character, enable_next_level
  );

  modport slave (
    input  scan_valid, scan_code, comparison_data, num_char,
    output get_next_character, enable_next_level
  );
endinterface

// File: rtl/ps2_make_filter.sv
// Strips PS/2 set-2 break sequences, extended prefixes and shift keys, leaving a
// registered one-cycle make-code strobe.
module ps2_make_filter
  import typer_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       make_valid,
  output logic [7:0] make_code
);

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       make_valid_q, make_valid_d;
  logic [7:0] make_code_q, make_code_d;

  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    make_valid_d = 1'b0;
    make_code_d  = make_code_q;
    if (scan_valid) begin
      if (scan_code == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (scan_code == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (is_shift(scan_code)) begin
        ext_d = 1'b0;
      end else begin
        // extended makes pass through as their low byte
        make_valid_d = 1'b1;
        make_code_d  = scan_code;
        ext_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      make_valid_q <= 1'b0;
      make_code_q  <= 8'd0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      make_valid_q <= make_valid_d;
      make_code_q  <= make_code_d;
    end
  end

  assign make_valid = make_valid_q;
  assign make_code  = make_code_q;

endmodule

// File: rtl/typing_checker.sv
// Typing game checker: compares make codes with the parser's character and sequences levels.
// Define TYPER_ERROR_COUNT_EN to build the saturating mismatch counter on error_count.
//
// state       | meaning
// IDLE        | waiting for start
// LOAD        | parser reloading a level, keys dropped
// CHECK_EMPTY | skip levels that are already complete (num_char = 0)
// WAIT_KEY    | waiting for a make code
// COMPARE     | registered make code vs comparison_data
// ADVANCE     | parser shift settling
// LEVEL_DONE  | bump level, decide next level or game over
// GAME_OVER   | game_done high until reset
module typing_checker
  import typer_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int LOAD_WAIT  = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  typing_checker_if.slave bus,
  output logic [7:0]      char_index,
  output logic [3:0]      level_count,
  output logic [7:0]      error_count,
  output logic            game_done
);

  localparam logic [7:0] LOAD_WAIT_V  = 8'(LOAD_WAIT);
  localparam logic [3:0] NUM_LEVELS_V = 4'(NUM_LEVELS);

  logic       make_valid;
  logic [7:0] make_code;

  ps2_make_filter u_filter (
    .clk        (clk),
    .resetn     (resetn),
    .scan_valid (bus.scan_valid),
    .scan_code  (bus.scan_code),
    .make_valid (make_valid),
    .make_code  (make_code)
  );

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] code_q, code_d;
  logic [7:0] char_index_q, char_index_d, ci_inc;
  logic [3:0] level_q, level_d;
  logic       gnc_q, gnc_d;
  logic       enl_q, enl_d;
  logic       done_q, done_d;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    code_d       = code_q;
    char_index_d = char_index_q;
    level_d      = level_q;
    done_d       = done_q;
    gnc_d        = 1'b0;
    enl_d        = 1'b0;
    ci_inc       = char_index_q + 8'd1;
    case (state_q)
      ST_IDLE: if (start) begin
        enl_d   = 1'b1;
        wait_d  = LOAD_WAIT_V;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (wait_q == 8'd0) state_d = ST_CHECK_EMPTY;
        else                wait_d  = wait_q - 8'd1;
      end
      ST_CHECK_EMPTY: state_d = (char_index_q >= bus.num_char) ? ST_LEVEL_DONE : ST_WAIT_KEY;
      ST_WAIT_KEY: if (make_valid) begin
        code_d  = make_code;
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (code_q == bus.comparison_data) begin
          char_index_d = ci_inc;
          // the last character of a level completes it without shifting the parser
          if (ci_inc == bus.num_char) begin
            state_d = ST_LEVEL_DONE;
          end else begin
            gnc_d   = 1'b1;
            state_d = ST_ADVANCE;
          end
        end else begin
          state_d = ST_WAIT_KEY;
        end
      end
      ST_ADVANCE: state_d = ST_WAIT_KEY;
      ST_LEVEL_DONE: begin
        level_d      = level_q + 4'd1;
        char_index_d = 8'd0;
        if (level_d == NUM_LEVELS_V) begin
          done_d  = 1'b1;
          state_d = ST_GAME_OVER;
        end else begin
          enl_d   = 1'b1;
          wait_d  = LOAD_WAIT_V;
          state_d = ST_LOAD;
        end
      end
      ST_GAME_OVER: state_d = ST_GAME_OVER;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      wait_q       <= 8'd0;
      code_q       <= 8'd0;
      char_index_q <= 8'd0;
      level_q      <= 4'd0;
      gnc_q        <= 1'b0;
      enl_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      code_q       <= code_d;
      char_index_q <= char_index_d;
      level_q      <= level_d;
      gnc_q        <= gnc_d;
      enl_q        <= enl_d;
      done_q       <= done_d;
    end
  end

`ifdef TYPER_ERROR_COUNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == ST_COMPARE && code_q != bus.comparison_data && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) err_q <= 8'd0;
    else         err_q <= err_d;
  end

  assign error_count = err_q;
`else
  assign error_count = 8'd0;
`endif

  assign bus.get_next_character = gnc_q;
  assign bus.enable_next_level  = enl_q;
  assign char_index             = char_index_q;
  assign level_count            = level_q;
  assign game_done              = done_q;

endmodule

// File: tb/tb_typing_checker.sv
// Scoreboard bench for typing_checker: expected parser pulses are queued by the stimulus
// and checked by a monitor whenever the checker pulses; a small parser model feeds it.
module tb_typing_checker;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] char_index;
  logic [3:0] level_count;
  logic [7:0] error_count;
  logic       game_done;

`ifdef TYPER_ERROR_COUNT_EN
  localparam logic [7:0] EXP_ERR1 = 8'd1;
`else
  localparam logic [7:0] EXP_ERR1 = 8'd0;
`endif

  typing_checker_if tif ();

  typing_checker #(.NUM_LEVELS(4), .LOAD_WAIT(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .bus         (tif),
    .char_index  (char_index),
    .level_count (level_count),
    .error_count (error_count),
    .game_done   (game_done)
  );

  always #5 clk = ~clk;

  // parser model: level 0 "HELLO", level 1 empty, level 2 "A", level 3 "XY"
  logic [7:0] words [4][5] = '{
    '{8'h33, 8'h24, 8'h4B, 8'h4B, 8'h44},
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h1C, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h2D, 8'h1B, 8'h00, 8'h00, 8'h00}
  };
  logic [7:0] lens [4] = '{8'd5, 8'd0, 8'd1, 8'd2};
  int p_cur, p_idx, p_loads;

  always @(posedge clk) begin
    if (!resetn) begin
      p_cur   <= 0;
      p_idx   <= 0;
      p_loads <= 0;
    end else if (tif.get_next_character) begin
      p_idx <= p_idx + 1;
    end else if (tif.enable_next_level) begin
      p_cur   <= p_loads % 4;
      p_idx   <= 0;
      p_loads <= p_loads + 1;
    end
  end

  assign tif.comparison_data = (p_idx < 5) ? words[p_cur][p_idx] : 8'h00;
  assign tif.num_char        = lens[p_cur];

  typedef struct packed {
    logic       is_enl;
    logic [7:0] ci;
    logic [3:0] lvl;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // monitor: every pulse must match the oldest queued expectation
  ev_t mon_e;
  always @(negedge clk) begin
    if (resetn && (tif.get_next_character || tif.enable_next_level)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: gnc=%0b enl=%0b, want no pulse",
                 tif.get_next_character, tif.enable_next_level);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind", {30'd0, tif.get_next_character, tif.enable_next_level},
            mon_e.is_enl ? 32'd1 : 32'd2);
        chk("pulse_char_index", 32'(char_index), 32'(mon_e.ci));
        chk("pulse_level_count", 32'(level_count), 32'(mon_e.lvl));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tif.scan_valid = 1'b1;
    tif.scan_code  = b;
    tick(1);
    tif.scan_valid = 1'b0;
    tick(6);
  endtask

  task automatic key(input logic [7:0] m);
    send(m);
    send(8'hF0);
    send(m);
  endtask

  task automatic expect_ev(input logic enl, input logic [7:0] ci, input logic [3:0] lvl);
    ev_t e;
    e.is_enl = enl;
    e.ci     = ci;
    e.lvl    = lvl;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnc"}, 32'(tif.get_next_character), 32'd0);
    chk({tag, "_enl"}, 32'(tif.enable_next_level), 32'd0);
    chk({tag, "_char_index"}, 32'(char_index), 32'd0);
    chk({tag, "_level_count"}, 32'(level_count), 32'd0);
    chk({tag, "_error_count"}, 32'(error_count), 32'd0);
    chk({tag, "_game_done"}, 32'(game_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tif.scan_valid = 1'b0;
    tif.scan_code  = 8'h00;
    tick(3);
    chk_all_zero("reset");
    resetn = 1'b1;
    tick(2);

    // start held high while keys arrive during LOAD: one load pulse, no shifts
    expect_ev(1'b1, 8'd0, 4'd0);
    start = 1'b1;
    tick(1);
    tif.scan_valid = 1'b1;
    tif.scan_code  = 8'h33;
    tick(2);
    tif.scan_valid = 1'b0;
    start = 1'b0;
    tick(10);
    drain("start_enl");
    chk("ci_after_load", 32'(char_index), 32'd0);

    // wrong key while 0x33 expected
    key(8'h1C);
    chk("err_after_wrong", 32'(error_count), 32'(EXP_ERR1));
    chk("ci_after_wrong", 32'(char_index), 32'd0);

    // break of the expected key alone, then shift codes
    send(8'hF0);
    send(8'h33);
    chk("ci_after_break", 32'(char_index), 32'd0);
    send(8'h12);
    send(8'h59);
    chk("ci_after_shift", 32'(char_index), 32'd0);
    chk("err_after_shift", 32'(error_count), 32'(EXP_ERR1));

    // extended make compared by its low byte
    expect_ev(1'b0, 8'd1, 4'd0);
    send(8'hE0);
    send(8'h33);
    send(8'hE0);
    send(8'hF0);
    send(8'h33);
    drain("ext_match");

    expect_ev(1'b0, 8'd2, 4'd0);
    key(8'h24);
    expect_ev(1'b0, 8'd3, 4'd0);
    key(8'h4B);
    expect_ev(1'b0, 8'd4, 4'd0);
    key(8'h4B);
    chk("ci_before_last", 32'(char_index), 32'd4);

    // last key ends level 0; level 1 is empty and completes without a key
    expect_ev(1'b1, 8'd0, 4'd1);
    expect_ev(1'b1, 8'd0, 4'd2);
    key(8'h44);
    tick(10);
    drain("levels_0_1");
    chk("level_after_empty", 32'(level_count), 32'd2);
    chk("not_done_yet", 32'(game_done), 32'd0);

    expect_ev(1'b1, 8'd0, 4'd3);
    key(8'h1C);
    tick(10);
    drain("level_2");

    expect_ev(1'b0, 8'd1, 4'd3);
    key(8'h2D);
    key(8'h1B);
    tick(10);
    drain("level_3");
    chk("game_done", 32'(game_done), 32'd1);
    chk("final_level", 32'(level_count), 32'd4);
    chk("final_ci", 32'(char_index), 32'd0);
    chk("final_err", 32'(error_count), 32'(EXP_ERR1));

    // game over ignores keys and start
    key(8'h2D);
    start = 1'b1;
    tick(5);
    start = 1'b0;
    key(8'h1B);
    tick(5);
    chk("game_over_held", 32'(game_done), 32'd1);

    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    chk_all_zero("midgame_reset");

    // back in IDLE: start produces a fresh load pulse
    expect_ev(1'b1, 8'd0, 4'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    drain("restart_enl");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/typing_checker.md
# typing_checker

Downstream consumer of the keyboard parser stage. It receives PS/2 set-2 scan bytes, filters them to make codes, and compares each one against the parser's current `comparison_data` character. On a match it advances the parser with a one-cycle `get_next_character` pulse. After `num_char` matches it requests the next level with a one-cycle `enable_next_level` pulse. It also tracks the character index, completed levels and the game-done condition for the display and score logic.

## Interface
Parameters:
- `NUM_LEVELS`, 4: levels played before game over (1..15).
- `LOAD_WAIT`, 4: cycles held after each `enable_next_level` pulse before the next compare. Covers the parser's reload latency; minimum is 3.

Ports:
- `clk` input 1: system clock. This is the only clock.
- `resetn` input 1: reset. Synchronous and active-low, sampled on the rising edge of `clk`.
- `start` input 1: level-sensitive; begins a game when the block is in IDLE.
- `scan_valid` input 1: one-cycle strobe qualifying `scan_code`, from the PS/2 receiver.
- `scan_code` input 8: raw set-2 scan byte.
- `comparison_data` input 8: expected make code, from the parser.
- `num_char` input 8: character count of the current level, from the parser.
- `get_next_character` output 1: one-cycle pulse that shifts the parser to its next character.
- `enable_next_level` output 1: one-cycle pulse that makes the parser load the next level.
- `char_index` output 8: number of characters matched in the current level.
- `level_count` output 4: number of levels completed.
- `error_count` output 8: saturating count of mismatched keystrokes. Present only with `TYPER_ERROR_COUNT_EN`.
- `game_done` output 1: high after `NUM_LEVELS` levels are complete.

## Operation
Make-code filter (sub-module):
- Tracks prefix bytes in every state.
- 0xE0 sets an extended flag. 0xF0 sets a break flag.
- The byte after 0xF0 is discarded, and both flags then clear.
- Shift codes 0x12 and 0x59 are discarded.
- Every other byte produces `make_valid`, a one-cycle strobe, with `make_code`, both registered one cycle after `scan_valid`.
- An extended make code is passed through with its low byte only.

FSM states:
- IDLE: when `start` is high, pulse `enable_next_level`, load the wait counter with `LOAD_WAIT`, go to LOAD.
- LOAD: decrement the wait counter; at 0, go to CHECK_EMPTY. `make_valid` strobes in this state are dropped.
- CHECK_EMPTY: if `char_index >= num_char`, go to LEVEL_DONE. This covers `num_char = 0`. Otherwise go to WAIT_KEY.
- WAIT_KEY: on `make_valid`, go to COMPARE with `make_code` registered.
- COMPARE, match (`make_code == comparison_data`):
  - increment `char_index`;
  - if the new `char_index == num_char`, go to LEVEL_DONE without pulsing `get_next_character`;
  - otherwise pulse `get_next_character` and go to ADVANCE.
- COMPARE, mismatch: increment `error_count` (if the macro is enabled, saturating at 0xFF) and return to WAIT_KEY. `char_index` does not change.
- ADVANCE: one cycle for the parser's shift to settle, then go to WAIT_KEY.
- LEVEL_DONE: increment `level_count` and clear `char_index`.
  - If the new `level_count == NUM_LEVELS`, go to GAME_OVER.
  - Otherwise pulse `enable_next_level`, load the wait counter, go to LOAD.
- GAME_OVER: `game_done` is high. Stay until reset. `start` is ignored.

Rules:
- `get_next_character` and `enable_next_level` are never high in the same cycle. The parser gives the shift priority over the load.
- `start` is ignored in every state except IDLE.

## Timing
- Reset: state is IDLE, filter flags clear, and every output is 0: `get_next_character`, `enable_next_level`, `char_index`, `level_count`, `error_count`, `game_done`.
- Reset mid-game returns to IDLE on the next edge. The parser shares `resetn`, so no resynchronisation is needed.
- All outputs are registered.
- Cycle counts, with `scan_valid` at cycle t:
  - `make_valid` at t+1;
  - COMPARE at t+2;
  - `get_next_character` at t+3;
  - `comparison_data` is valid again from t+4.
- Scan bytes may arrive back to back; the filter accepts one per cycle.
- A make code that arrives while the FSM is in COMPARE or ADVANCE is dropped. PS/2 byte spacing is on the order of 1 ms, so this never happens in normal use.
- `enable_next_level` at cycle e: CHECK_EMPTY is reached at e+`LOAD_WAIT`+1, when the parser's new `comparison_data` is valid.

## Configuration
`TYPER_ERROR_COUNT_EN`:
- Defined: the 8-bit saturating mismatch counter is built and drives `error_count`. It is cleared only by reset.
- Undefined: the counter logic is omitted and `error_count` is tied to 0. A mismatch still returns the FSM to WAIT_KEY.

## Structure
- Shared package `typer_pkg`:
  - FSM state typedef/encoding;
  - PS/2 constants: `PS2_BREAK` = 0xF0, `PS2_EXT` = 0xE0, `PS2_LSHIFT` = 0x12, `PS2_RSHIFT` = 0x59.
- Sub-module `ps2_make_filter`: the prefix tracker and make-code strobe generator.
- The top module `typing_checker` contains the FSM, the counters and the wait timer.

## Test plan
- Reset then `start`: `enable_next_level` pulses exactly once. Scan bytes sent during LOAD produce no `get_next_character`.
- Level "HELLO" (`num_char` 5, codes 33 24 4B 4B 44), each key sent as make then F0+make:
  - four `get_next_character` pulses;
  - `char_index` counts 1..5;
  - one `enable_next_level` pulse;
  - `level_count` = 1.
- Wrong key 0x1C while 0x33 is expected: no `get_next_character`, `char_index` stays 0, `error_count` = 1 (0 with the macro undefined). The correct key 0x33 then advances normally.
- Prefix and shift handling:
  - F0 33 alone never counts as a match;
  - E0 33 is compared as 0x33;
  - 12 59 produce no compare.
- `num_char` = 0 at load: goes straight to LEVEL_DONE and pulses `enable_next_level` with no key pressed.
- Complete 4 levels: `game_done` = 1 and `level_count` = 4, and further keys and `start` cause no pulses. Then `resetn` low for one cycle: all outputs are 0 and the state is IDLE.
